fifo_wr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single write port of the 4-bit async FIFO

---
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between producers, arbiter and FIFO.
// master: producer/FIFO side; slave: arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;

  modport master (
    output req, data, fifo_full,
    input  ack, grant, busy, fifo_wr_en, fifo_data_in
  );

  modport slave (
    input  req, data, fifo_full,
    output ack, grant, busy, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// FIFO_ARB_STATS_EN adds wr_count/stall_cnt counters.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  fifo_wr_arbiter_if.slave  bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N*8-1:0]    wr_count,
  output logic [7:0]        stall_cnt
`endif
);

  localparam int LW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q;
  logic [N-1:0]   grant_q;
  logic [LW-1:0]  last_q;
  logic [CW-1:0]  cnt_q;

  logic           own_req;
  logic           write;
  logic [W-1:0]   wdata;
  logic           pick_vld;
  logic [LW-1:0]  pick_idx;

  // Owner request, write qualifier and muxed owner data
  always_comb begin
    own_req = |(bus.req & grant_q);
    write   = (state_q == BURST) & own_req & ~bus.fifo_full;
    wdata   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) wdata = wdata | bus.data[i*W +: W];
    end
  end

  // Round-robin scan starting just after the last owner
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = LW'(idx);
      end
    end
  end

  assign bus.fifo_wr_en   = write;
  assign bus.ack          = grant_q & {N{write}};
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == BURST);
  assign bus.fifo_data_in = wdata;

  // Grant FSM: arbitrate in IDLE, count burst words in BURST
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(N - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q           <= '0;
            grant_q[pick_idx] <= 1'b1;
            last_q            <= pick_idx;
            cnt_q             <= '0;
            state_q           <= BURST;
          end
        end
        BURST: begin
          if (!own_req) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (write) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(MAX_BURST - 1)) begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [N*8-1:0] wr_count_q;
  logic [7:0]     stall_cnt_q;

  // Accepted-word and full-stall counters, wrapping at 255
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_count_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i])
          wr_count_q[i*8 +: 8] <= wr_count_q[i*8 +: 8] + 8'd1;
      end
      if ((state_q == BURST) && own_req && bus.fifo_full)
        stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

  assign wr_count  = wr_count_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: per-cycle vector table,
// write-data scoreboard and a mid-burst async reset sequence.
module tb_fifo_wr_arbiter;

  logic wr_clk;
  logic wr_rst;

  fifo_wr_arbiter_if #(.N(4), .W(4)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] wr_count;
  logic [7:0]  stall_cnt;
`endif

  fifo_wr_arbiter #(.N(4), .W(4), .MAX_BURST(4)) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .bus       (bus.slave)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count  (wr_count),
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       wr;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];
  int         exp_cnt[4];
  int         checks;
  int         errors;
  logic [15:0] data_v;

  function automatic vec_t v(logic r, logic [3:0] q, logic f,
                             logic [3:0] g, logic [3:0] a,
                             logic w, logic b);
    vec_t t;
    t.rst = r; t.req = q; t.full = f;
    t.grant = g; t.ack = a; t.wr = w; t.busy = b;
    return t;
  endfunction

  task automatic add(input vec_t t, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endtask

  task automatic check_out(input vec_t t, input string nm);
    logic [3:0] got;
    checks++;
    if (bus.grant !== t.grant || bus.ack !== t.ack ||
        bus.fifo_wr_en !== t.wr || bus.busy !== t.busy) begin
      errors++;
      $display("FAIL %s got g=%b a=%b w=%b b=%b exp g=%b a=%b w=%b b=%b",
               nm, bus.grant, bus.ack, bus.fifo_wr_en, bus.busy,
               t.grant, t.ack, t.wr, t.busy);
    end
    if (t.grant == 4'b0) begin
      checks++;
      if (bus.fifo_data_in !== 4'h0) begin
        errors++;
        $display("FAIL %s idle_data got %h exp 0", nm, bus.fifo_data_in);
      end
    end
    if (bus.fifo_wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_write got %h exp none",
                 nm, bus.fifo_data_in);
      end else begin
        got = sb.pop_front();
        if (bus.fifo_data_in !== got) begin
          errors++;
          $display("FAIL %s wdata got %h exp %h",
                   nm, bus.fifo_data_in, got);
        end
      end
    end
  endtask

  task automatic apply(input vec_t t, input string nm);
    @(negedge wr_clk);
    wr_rst        = t.rst;
    bus.req       = t.req;
    bus.fifo_full = t.full;
    if (t.rst) begin
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end
    if (t.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (t.grant[i]) begin
          sb.push_back(data_v[i*4 +: 4]);
          exp_cnt[i]++;
        end
      end
    end
    #1;
    check_out(t, nm);
  endtask

  initial begin
    int mark_t4;
    checks = 0;
    errors = 0;
    data_v = 16'hDCA9;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    wr_rst        = 1'b1;
    bus.req       = 4'b1111;
    bus.data      = data_v;
    bus.fifo_full = 1'b0;

    // reset with all requesting
    add(v(1, 4'hF, 0, 4'h0, 4'h0, 0, 0), 2);
    // all requesting: 0,1,2,3,0 with 4 writes and a bubble
    add(v(0, 4'hF, 0, 4'h0, 4'h0, 0, 0), 1);
    for (int r = 0; r < 4; r++) begin
      add(v(0, 4'hF, 0, 4'(1 << r), 4'(1 << r), 1, 1), 4);
      add(v(0, 4'hF, 0, 4'h0, 4'h0, 0, 0), 1);
    end
    add(v(0, 4'hF, 0, 4'h1, 4'h1, 1, 1), 4);
    add(v(0, 4'h0, 0, 4'h0, 4'h0, 0, 0), 1);
    // single requester 1, re-grant after bubble, then drop
    add(v(0, 4'h2, 0, 4'h0, 4'h0, 0, 0), 1);
    add(v(0, 4'h2, 0, 4'h2, 4'h2, 1, 1), 4);
    add(v(0, 4'h2, 0, 4'h0, 4'h0, 0, 0), 1);
    add(v(0, 4'h2, 0, 4'h2, 4'h2, 1, 1), 1);
    add(v(0, 4'h0, 0, 4'h2, 4'h0, 0, 1), 1);
    add(v(0, 4'h0, 0, 4'h0, 4'h0, 0, 0), 1);
    // requester 3 stalled by full for 3 cycles after 2 writes
    add(v(0, 4'h8, 0, 4'h0, 4'h0, 0, 0), 1);
    add(v(0, 4'h8, 0, 4'h8, 4'h8, 1, 1), 2);
    add(v(0, 4'h8, 1, 4'h8, 4'h0, 0, 1), 3);
    add(v(0, 4'h8, 0, 4'h8, 4'h8, 1, 1), 2);
    mark_t4 = tbl.size();
    add(v(0, 4'h0, 0, 4'h0, 4'h0, 0, 0), 1);
    // requester 2 drops after one write (full high), 3 wins next
    add(v(0, 4'h4, 0, 4'h0, 4'h0, 0, 0), 1);
    add(v(0, 4'h4, 0, 4'h4, 4'h4, 1, 1), 1);
    add(v(0, 4'h9, 1, 4'h4, 4'h0, 0, 1), 1);
    add(v(0, 4'h9, 0, 4'h0, 4'h0, 0, 0), 1);
    add(v(0, 4'h9, 0, 4'h8, 4'h8, 1, 1), 1);
    add(v(0, 4'h0, 0, 4'h8, 4'h0, 0, 1), 1);
    add(v(0, 4'h0, 0, 4'h0, 4'h0, 0, 0), 1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
`ifdef FIFO_ARB_STATS_EN
      if (i == mark_t4) begin
        checks++;
        if (stall_cnt !== 8'd3) begin
          errors++;
          $display("FAIL stall_cnt got %0d exp 3", stall_cnt);
        end
      end
`endif
    end

    // async reset mid-burst on requester 2
    apply(v(0, 4'h4, 0, 4'h0, 4'h0, 0, 0), "rst_pre");
    apply(v(0, 4'h4, 0, 4'h4, 4'h4, 1, 1), "rst_burst");
    #2;
    wr_rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    #1;
    check_out(v(1, 4'h4, 0, 4'h0, 4'h0, 0, 0), "rst_async");
    apply(v(1, 4'h5, 0, 4'h0, 4'h0, 0, 0), "rst_hold");
    apply(v(0, 4'h5, 0, 4'h0, 4'h0, 0, 0), "rst_rel");
    apply(v(0, 4'h5, 0, 4'h1, 4'h1, 1, 1), "rst_g0");
    apply(v(0, 4'h0, 0, 4'h1, 4'h0, 0, 1), "rst_drop");
    apply(v(0, 4'h0, 0, 4'h0, 4'h0, 0, 0), "rst_idle");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d exp 0", sb.size());
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_count[i*8 +: 8] !== 8'(exp_cnt[i])) begin
        errors++;
        $display("FAIL wr_count%0d got %0d exp %0d",
                 i, wr_count[i*8 +: 8], exp_cnt[i]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
